// File: rtl/spi_sclk_gen_if.sv
// SPI serial-clock generator bus: transfer control, divider and chip-select
// configuration in; serial clock, edge strobes, slave selects and status out.
interface spi_sclk_gen_if #(
  parameter int DIV_LEN = 16,
  parameter int SS_NB   = 8
);
  logic               go;
  logic               stop;
  logic               last;
  logic [DIV_LEN-1:0] divider;
  logic               cpol;
  logic [SS_NB-1:0]   ss_mask;
  logic [7:0]         cs_setup;
  logic [7:0]         cs_hold;
  logic               s_clk;
  logic               pos_edge;
  logic               neg_edge;
  logic [SS_NB-1:0]   ss_pad_o;
  logic               busy;
  logic               done;

  modport master (
    output go, stop, last, divider, cpol, ss_mask, cs_setup, cs_hold,
    input  s_clk, pos_edge, neg_edge, ss_pad_o, busy, done
  );

  modport slave (
    input  go, stop, last, divider, cpol, ss_mask, cs_setup, cs_hold,
    output s_clk, pos_edge, neg_edge, ss_pad_o, busy, done
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator. Produces s_clk with a programmable half-period
// (divider+1 clk cycles), one-cycle leading/trailing edge strobes and
// active-low slave selects for the duration of a transfer.
// Optional feature macro: SPI_CS_DELAY_EN adds chip-select setup (SETUP) and
// hold (HOLD) phases around the clocking phase; without it cs_setup/cs_hold
// are accepted but ignored.
module spi_sclk_gen #(
  parameter int DIV_LEN = 16,
  parameter int SS_NB   = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_sclk_gen_if.slave bus
);

`ifdef SPI_CS_DELAY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd2
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [DIV_LEN-1:0] cnt;
  logic [DIV_LEN-1:0] cnt_nxt;
  logic               sclk_i;
  logic               sclk_nxt;
  logic               done_r;
  logic               done_nxt;
  logic               latch;
  logic [DIV_LEN-1:0] div_l;
  logic [SS_NB-1:0]   mask_l;
  logic               cpol_l;
  logic               strobe;
  logic               busy_i;

`ifdef SPI_CS_DELAY_EN
  logic [7:0]         dly;
  logic [7:0]         dly_nxt;
`else
  logic               unused_cfg;
  assign unused_cfg = ^{bus.cs_setup, bus.cs_hold};
`endif

  // A strobe fires on the last cycle of every half-period while clocking
  assign strobe = (state == RUN) && (cnt == '0);

  // Next-state, phase counter and internal clock decisions
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sclk_nxt  = sclk_i;
    done_nxt  = 1'b0;
    latch     = 1'b0;
`ifdef SPI_CS_DELAY_EN
    dly_nxt   = dly;
`endif
    case (state)
      IDLE: begin
        if (bus.go && !bus.stop) begin
          latch = 1'b1;
`ifdef SPI_CS_DELAY_EN
          if (bus.cs_setup != 8'd0) begin
            state_nxt = SETUP;
            dly_nxt   = bus.cs_setup - 8'd1;
          end else
`endif
          begin
            state_nxt = RUN;
            cnt_nxt   = bus.divider;
            sclk_nxt  = 1'b0;
          end
        end
      end
`ifdef SPI_CS_DELAY_EN
      SETUP: begin
        if (dly == 8'd0) begin
          state_nxt = RUN;
          cnt_nxt   = div_l;
          sclk_nxt  = 1'b0;
        end else begin
          dly_nxt = dly - 8'd1;
        end
      end
`endif
      RUN: begin
        if (cnt == '0) begin
          // The final leading edge is still strobed but sclk_i stays low
          if (!sclk_i && bus.last) begin
`ifdef SPI_CS_DELAY_EN
            if (bus.cs_hold != 8'd0) begin
              state_nxt = HOLD;
              dly_nxt   = bus.cs_hold - 8'd1;
            end else
`endif
            begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt  = div_l;
            sclk_nxt = ~sclk_i;
          end
        end else begin
          cnt_nxt = cnt - DIV_LEN'(1);
        end
      end
`ifdef SPI_CS_DELAY_EN
      HOLD: begin
        if (dly == 8'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          dly_nxt = dly - 8'd1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Abort beats everything, including a simultaneous end of clocking
    if (state != IDLE && bus.stop) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end
    if (state_nxt == IDLE) begin
      cnt_nxt  = '0;
      sclk_nxt = 1'b0;
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sclk_i <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sclk_i <= sclk_nxt;
      done_r <= done_nxt;
    end
  end

`ifdef SPI_CS_DELAY_EN
  // Chip-select setup/hold cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= 8'd0;
    end else begin
      dly <= dly_nxt;
    end
  end
`endif

  // Idle polarity follows cpol while idle and freezes for the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_l <= 1'b0;
    end else if (state == IDLE) begin
      cpol_l <= bus.cpol;
    end
  end

  // Transfer configuration captured at go; only consumed while busy
  always_ff @(posedge clk) begin
    if (latch) begin
      div_l  <= bus.divider;
      mask_l <= bus.ss_mask;
    end
  end

  assign busy_i       = (state != IDLE);
  assign bus.busy     = busy_i;
  assign bus.done     = done_r;
  assign bus.ss_pad_o = busy_i ? ~mask_l : {SS_NB{1'b1}};
  assign bus.s_clk    = (state == RUN) ? (sclk_i ^ cpol_l) : cpol_l;
  assign bus.pos_edge = strobe && !sclk_i;
  assign bus.neg_edge = strobe && sclk_i;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Testbench for spi_sclk_gen: directed and randomized transfers compared
// cycle by cycle against a timeline model derived from the transfer rules.
module tb_spi_sclk_gen;
  localparam int DIV_LEN = 16;
  localparam int SS_NB   = 8;

  typedef logic [SS_NB+4:0] obs_t; // {s_clk, pos, neg, busy, done, ss_pad_o}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sclk_gen_if #(.DIV_LEN(DIV_LEN), .SS_NB(SS_NB)) bus ();

  spi_sclk_gen #(.DIV_LEN(DIV_LEN), .SS_NB(SS_NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_id = 0;

  // Timeline of the current transfer, in cycles after the go-sampling edge:
  // clocking spans [m_r, m_e], done pulses at m_f, optional abort at m_stop.
  int               m_r, m_p, m_e, m_f, m_stop;
  logic             m_cpol;
  logic [SS_NB-1:0] m_mask;

  function automatic obs_t idle_obs(logic cp, logic dn);
    return {cp, 1'b0, 1'b0, 1'b0, dn, {SS_NB{1'b1}}};
  endfunction

  function automatic obs_t expect_at(int t);
    logic sc, pe, ne, bz, dn;
    logic [SS_NB-1:0] ss;
    int k, ph;
    sc = m_cpol; pe = 1'b0; ne = 1'b0; bz = 1'b0; dn = 1'b0; ss = {SS_NB{1'b1}};
    if (!(m_stop > 0 && t > m_stop)) begin
      if (t >= 1 && t < m_f) begin
        bz = 1'b1;
        ss = ~m_mask;
        if (t >= m_r && t <= m_e) begin
          k  = (t - m_r) / m_p;
          ph = (t - m_r) % m_p;
          sc = ((k % 2) == 1) ^ m_cpol;
          if (ph == m_p - 1) begin
            if ((k % 2) == 0) pe = 1'b1;
            else              ne = 1'b1;
          end
        end
      end else if (t == m_f) begin
        dn = 1'b1;
      end
    end
    return {sc, pe, ne, bz, dn, ss};
  endfunction

  function automatic bit is_pos(int t);
    if (t < m_r || t > m_e) return 1'b0;
    return (((t - m_r) % m_p) == m_p - 1) && ((((t - m_r) / m_p) % 2) == 0);
  endfunction

  function automatic obs_t observe();
    return {bus.s_clk, bus.pos_edge, bus.neg_edge, bus.busy, bus.done, bus.ss_pad_o};
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = observe();
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transfer started from IDLE right after a falling edge.
  // stop_sel: 0 none, >0 abort cycle, <0 random. do_rst pulses rst_n mid-transfer.
  task automatic run_xfer(input int d, input logic cp, input logic [SS_NB-1:0] mk,
                          input int s, input int h, input int n, input int stop_sel,
                          input bit hold_go, input bit do_rst);
    int eff_s, eff_h, end_t, rst_t;
    obs_t exp;
    xfer_id++;
`ifdef SPI_CS_DELAY_EN
    eff_s = s; eff_h = h;
`else
    eff_s = 0; eff_h = 0;
`endif
    m_p    = d + 1;
    m_r    = 1 + eff_s;
    m_e    = m_r + 2 * (n - 1) * m_p + m_p - 1;
    m_f    = m_e + eff_h + 1;
    m_cpol = cp;
    m_mask = mk;
    if (stop_sel < 0) m_stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, m_f - 1)) : 0;
    else              m_stop = stop_sel;
    rst_t = do_rst ? ((eff_h > 1) ? m_e + 2 : m_e - 1) : 0;
    end_t = (m_stop > 0) ? m_stop : m_f;

    bus.divider  = DIV_LEN'(d);
    bus.cpol     = cp;
    bus.ss_mask  = mk;
    bus.cs_setup = 8'(s);
    bus.cs_hold  = 8'(h);
    bus.last     = 1'b0;
    bus.stop     = 1'b0;
    bus.go       = 1'b1;

    for (int t = 1; t <= end_t + 1; t++) begin
      @(negedge clk);
      exp = (hold_go && t == m_f + 1) ? expect_at(1) : expect_at(t);
      check($sformatf("xfer%0d_t%0d", xfer_id, t), exp);
      if (t == rst_t) begin
        #2 rst_n = 1'b0;
        #1 check($sformatf("xfer%0d_rst_async", xfer_id), idle_obs(1'b0, 1'b0));
        bus.go = 1'b0; bus.stop = 1'b0; bus.last = 1'b0; bus.cpol = cp;
        @(negedge clk);
        check($sformatf("xfer%0d_rst_held", xfer_id), idle_obs(1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check($sformatf("xfer%0d_rst_release", xfer_id), idle_obs(cp, 1'b0));
        return;
      end
      if (!hold_go) bus.go = 1'b0;
      if (t < end_t) begin
        bus.divider = DIV_LEN'($urandom);
        bus.cpol    = 1'($urandom);
        bus.ss_mask = SS_NB'($urandom);
      end else begin
        bus.divider = DIV_LEN'(d);
        bus.cpol    = cp;
        bus.ss_mask = mk;
      end
      bus.last = (t == m_e) || (t < m_e && !is_pos(t) && $urandom_range(0, 1) == 1);
      bus.stop = (t == m_stop);
    end
    if (hold_go) begin
      bus.go   = 1'b0;
      bus.stop = 1'b1;
      @(negedge clk);
      check($sformatf("xfer%0d_chain_stop", xfer_id), idle_obs(cp, 1'b0));
      bus.stop = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go = 1'b0; bus.stop = 1'b0; bus.last = 1'b0; bus.divider = '0;
    bus.cpol = 1'b0; bus.ss_mask = '0; bus.cs_setup = 8'd0; bus.cs_hold = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_state", idle_obs(1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", idle_obs(1'b0, 1'b0));

    // go together with stop in IDLE is ignored
    bus.go = 1'b1; bus.stop = 1'b1; bus.ss_mask = 8'h55;
    @(negedge clk);
    check("go_stop_idle", idle_obs(1'b0, 1'b0));
    bus.go = 1'b0; bus.stop = 1'b0;

    run_xfer(3, 1'b0, 8'h01, 0, 0, 4, 0, 1'b0, 1'b0);   // half-period 4, period 8
    run_xfer(1, 1'b1, 8'h81, 0, 0, 9, 0, 1'b0, 1'b0);   // 8 pulses idling high
    run_xfer(2, 1'b0, 8'h04, 5, 3, 3, 0, 1'b0, 1'b0);   // CS setup 5 / hold 3
    run_xfer(2, 1'b1, 8'h10, 0, 0, 4, 6, 1'b0, 1'b0);   // abort mid-clocking
    run_xfer(2, 1'b1, 8'h10, 0, 0, 2, 0, 1'b0, 1'b0);   // restart after abort
    run_xfer(1, 1'b0, 8'h20, 0, 0, 2, 6, 1'b0, 1'b0);   // abort on final edge
    run_xfer(1, 1'b0, 8'h02, 2, 3, 2, 0, 1'b0, 1'b1);   // reset mid-hold
    run_xfer(1, 1'b1, 8'h40, 0, 0, 3, 0, 1'b0, 1'b0);   // first go after reset
    run_xfer(0, 1'b0, 8'hFF, 0, 0, 3, 0, 1'b1, 1'b0);   // divider 0, go held

    for (int i = 0; i < 16; i++) begin
      run_xfer(int'($urandom_range(0, 4)), 1'($urandom), SS_NB'($urandom_range(1, 255)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 4)), -1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
